// File: rtl/cmem_port_arbiter.sv
// Two-requester round-robin arbiter for the single layer-memory port.
// Commands are registered; read data returns two cycles after grant, tagged to the issuer.
module cmem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 13,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          sel0,
  input  logic          sel1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic          crd,
  output logic          csel,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd,
  output logic          busy
);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  owner_e          r_last_owner;
  owner_e          r_rd_id;
  logic [3:0]      r_burst_cnt;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_keep;
  owner_e          w_id;
  logic            w_we;
  logic            w_sel;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  // A nonzero burst count means the last owner was also granted last cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_keep = (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX);
    if (reset) begin
      if (req0 && req1) begin
        if (w_keep ? (r_last_owner == OWN0) : (r_last_owner == OWN1))
          w_gnt0 = 1'b1;
        else
          w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  always_comb begin
    w_id    = w_gnt1 ? OWN1 : OWN0;
    w_we    = w_gnt1 ? we1 : we0;
    w_sel   = w_gnt1 ? sel1 : sel0;
    w_addr  = w_gnt1 ? addr1 : addr0;
    w_wdata = w_gnt1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner <= OWN1;
      r_rd_id      <= OWN0;
      r_burst_cnt  <= '0;
      cwr          <= 1'b0;
      crd          <= 1'b0;
      csel         <= 1'b0;
      caddr_wr     <= '0;
      caddr_rd     <= '0;
      cdata_wr     <= '0;
      rdata        <= '0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
    end else begin
      cwr     <= 1'b0;
      crd     <= 1'b0;
      rvalid0 <= crd && (r_rd_id == OWN0);
      rvalid1 <= crd && (r_rd_id == OWN1);
      if (crd)
        rdata <= cdata_rd;
      if (w_gnt0 || w_gnt1) begin
        r_last_owner <= w_id;
        if ((w_id == r_last_owner) && (r_burst_cnt != '0))
          r_burst_cnt <= (r_burst_cnt == BURST_MAX) ? BURST_MAX : r_burst_cnt + 4'd1;
        else
          r_burst_cnt <= 4'd1;
        csel <= w_sel;
        if (w_we) begin
          cwr      <= 1'b1;
          caddr_wr <= w_addr;
          cdata_wr <= w_wdata;
        end else begin
          crd      <= 1'b1;
          caddr_rd <= w_addr;
          r_rd_id  <= w_id;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;
  assign busy = reset & (crd | cwr | rvalid0 | rvalid1 | req0 | req1);

endmodule

// File: tb/tb_cmem_port_arbiter.sv
// Self-checking bench for cmem_port_arbiter: table vectors, directed sequences and
// randomized traffic against a transaction-level model with an ideal memory.
module tb_cmem_port_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, sel0 = 0, sel1 = 0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [12:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, cwr, crd, csel, busy;
  logic [12:0] rdata, cdata_wr, cdata_rd;
  logic [11:0] caddr_wr, caddr_rd;

  cmem_port_arbiter #(.AW(12), .DW(13), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .sel0(sel0), .sel1(sel1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
    .cdata_wr(cdata_wr), .cdata_rd(cdata_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Ideal single-port memory behind the arbiter
  logic [12:0] mem  [2][4096];
  logic [12:0] gold [2][4096];
  always @(posedge clk) if (cwr) mem[csel][caddr_wr] <= cdata_wr;
  assign cdata_rd = mem[csel][caddr_rd];

  function automatic logic [12:0] init_val(int s, int a);
    return 13'((a * 37 + s * 1111) ^ 'h0A5A);
  endfunction

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model state
  typedef struct { int due; int id; logic [12:0] data; } rd_t;
  rd_t pq[$];
  int m_last, m_streak;
  logic e_cwr, e_crd, e_csel;
  logic [11:0] e_awr, e_ard;
  logic [12:0] e_dwr;

  task automatic model_reset();
    m_last = 1; m_streak = 0; pq.delete();
    e_cwr = 0; e_crd = 0; e_csel = 0; e_awr = '0; e_ard = '0; e_dwr = '0;
    gold = mem;
  endtask

  // Called at a falling edge with inputs already driven; returns granted id or -1.
  task automatic step(output int g);
    logic rv0, rv1, w, s; logic [11:0] a; logic [12:0] d; rd_t r;
    #2;
    chk("cwr", cwr, e_cwr);   chk("crd", crd, e_crd);   chk("csel", csel, e_csel);
    chk("caddr_wr", caddr_wr, e_awr); chk("caddr_rd", caddr_rd, e_ard);
    chk("cdata_wr", cdata_wr, e_dwr);
    chk("cwr_crd_exclusive", cwr & crd, 1'b0);
    rv0 = 0; rv1 = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      r = pq.pop_front();
      if (r.id == 0) rv0 = 1; else rv1 = 1;
      chk("rdata", rdata, r.data);
    end
    chk("rvalid0", rvalid0, rv0); chk("rvalid1", rvalid1, rv1);
    chk("busy", busy, e_crd | e_cwr | rv0 | rv1 | req0 | req1);
    if (req0 && req1) g = (m_streak > 0 && m_streak < MAXB) ? m_last : 1 - m_last;
    else if (req0) g = 0;
    else if (req1) g = 1;
    else g = -1;
    chk("gnt0", gnt0, g == 0); chk("gnt1", gnt1, g == 1);
    e_cwr = 0; e_crd = 0;
    if (g < 0) m_streak = 0;
    else begin
      m_streak = (g == m_last && m_streak > 0) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
      m_last = g;
      w = g ? we1 : we0; s = g ? sel1 : sel0; a = g ? addr1 : addr0; d = g ? wdata1 : wdata0;
      e_csel = s;
      if (w) begin
        e_cwr = 1; e_awr = a; e_dwr = d; gold[s][a] = d;
      end else begin
        e_crd = 1; e_ard = a;
        pq.push_back('{due: cyc + 2, id: g, data: gold[s][a]});
      end
    end
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  typedef struct {
    logic r0, r1, w0, w1, s0, s1; logic [11:0] a0, a1; logic [12:0] d0, d1;
    logic g0, g1, cwr, crd, csel; logic [11:0] awr, ard; logic [12:0] dwr;
  } vec_t;

  logic act [2], rw [2], rs [2];
  logic [11:0] ra [2];
  logic [12:0] rd [2];

  task automatic rnd_params(int i);
    rw[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
    ra[i] = 12'($urandom_range(0, 31)); rd[i] = 13'($urandom);
  endtask

  initial begin
    vec_t tbl [5];
    int g, ng, ns;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4096; a++) mem[s][a] = init_val(s, a);
    mem[0][5] = 13'h0123;

    // Reset state
    #3;
    chk("rst_cwr", cwr, 0); chk("rst_crd", crd, 0); chk("rst_csel", csel, 0);
    chk("rst_caddr_wr", caddr_wr, 0); chk("rst_caddr_rd", caddr_rd, 0);
    chk("rst_cdata_wr", cdata_wr, 0); chk("rst_rdata", rdata, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0); chk("rst_busy", busy, 0);

    // Single-cycle vectors, each from a fresh reset
    tbl[0] = '{0,0,0,0,0,0, 12'h000,12'h000, 13'h0000,13'h0000, 0,0, 0,0,0, 12'h000,12'h000,13'h0000};
    tbl[1] = '{1,0,0,0,0,0, 12'h005,12'h000, 13'h0000,13'h0000, 1,0, 0,1,0, 12'h000,12'h005,13'h0000};
    tbl[2] = '{0,1,0,1,0,1, 12'h000,12'h3FF, 13'h0000,13'h1ABC, 0,1, 1,0,1, 12'h3FF,12'h000,13'h1ABC};
    tbl[3] = '{1,1,1,0,1,0, 12'h010,12'h020, 13'h0055,13'h0000, 1,0, 1,0,1, 12'h010,12'h000,13'h0055};
    tbl[4] = '{1,1,0,1,0,1, 12'h022,12'h033, 13'h0000,13'h0077, 1,0, 0,1,0, 12'h000,12'h022,13'h0000};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      req0 = tbl[i].r0; req1 = tbl[i].r1; we0 = tbl[i].w0; we1 = tbl[i].w1;
      sel0 = tbl[i].s0; sel1 = tbl[i].s1; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      wdata0 = tbl[i].d0; wdata1 = tbl[i].d1;
      #1;
      chk("tbl_gnt0", gnt0, tbl[i].g0); chk("tbl_gnt1", gnt1, tbl[i].g1);
      step(g);
      req0 = 0; req1 = 0;
      chk("tbl_cwr", cwr, tbl[i].cwr); chk("tbl_crd", crd, tbl[i].crd);
      chk("tbl_csel", csel, tbl[i].csel); chk("tbl_caddr_wr", caddr_wr, tbl[i].awr);
      chk("tbl_caddr_rd", caddr_rd, tbl[i].ard); chk("tbl_cdata_wr", cdata_wr, tbl[i].dwr);
    end

    // Read of L0 addr 5 returns 0x0123 two cycles after grant
    do_reset();
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h005;
    step(g); chk("rd5_gnt", g, 0);
    req0 = 0;
    step(g);
    chk("rd5_rvalid0", rvalid0, 1); chk("rd5_rdata", rdata, 13'h0123); chk("rd5_rvalid1", rvalid1, 0);
    step(g);

    // Both requesting continuously from reset: 8/8 alternation starting with 0
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; sel0 = 0; sel1 = 1;
    for (int i = 0; i < 40; i++) begin
      addr0 = 12'(i); addr1 = 12'(i + 64);
      step(g);
      chk("rr_owner", g, (i / 8) % 2);
    end
    req0 = 0; req1 = 0;
    repeat (3) step(g);

    // Lone requester is never throttled
    ng = 0; ns = 0;
    req0 = 1; sel0 = 0;
    for (int i = 0; i < 20; i++) begin
      we0 = 1'(i % 2); addr0 = 12'(100 + i); wdata0 = 13'(i);
      step(g);
      if (g == 0) ng++;
      if (cwr || crd) ns++;
    end
    req0 = 0;
    chk("lone_gnt_count", ng, 20); chk("lone_strobe_count", ns, 20);
    repeat (3) step(g);

    // Interleaved reads return in order, tagged to the issuer
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'd10; step(g);
    req0 = 0; req1 = 1; we1 = 0; sel1 = 0; addr1 = 12'd20; step(g);
    chk("il_rv0_a", rvalid0, 1); chk("il_rd_a", rdata, init_val(0, 10));
    req1 = 0; req0 = 1; addr0 = 12'd30; step(g);
    req0 = 0;
    chk("il_rv1", rvalid1, 1); chk("il_rd_b", rdata, init_val(0, 20));
    step(g);
    chk("il_rv0_c", rvalid0, 1); chk("il_rd_c", rdata, init_val(0, 30));
    step(g);

    // Write-after-read on consecutive cycles: read sees pre-write data
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h040; step(g);
    req0 = 0; req1 = 1; we1 = 1; sel1 = 0; addr1 = 12'h040; wdata1 = 13'h1FFF; step(g);
    req1 = 0;
    chk("war_old", rdata, init_val(0, 'h40));
    req0 = 1; step(g);
    req0 = 0; step(g);
    chk("war_new", rdata, 13'h1FFF);
    step(g);

    // Reset the cycle after a read grant: in-flight read is lost
    req0 = 1; we0 = 0; sel0 = 0; addr0 = 12'h005; step(g);
    req0 = 0; req1 = 1; we1 = 0;
    chk("rm_crd_before", crd, 1);
    reset = 0; #1;
    chk("rm_crd", crd, 0); chk("rm_cwr", cwr, 0); chk("rm_rvalid0", rvalid0, 0);
    chk("rm_rvalid1", rvalid1, 0); chk("rm_busy", busy, 0); chk("rm_gnt1", gnt1, 0);
    chk("rm_caddr_rd", caddr_rd, 0);
    repeat (2) @(negedge clk);
    req1 = 0; reset = 1; model_reset();
    for (int i = 0; i < 4; i++) begin
      step(g); chk("rm_no_rvalid", rvalid0 | rvalid1, 0);
    end
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    step(g); chk("rm_first_contention", g, 0);
    req0 = 0; req1 = 0;
    repeat (3) step(g);

    // Randomized traffic
    act[0] = 0; act[1] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++)
        if (!act[i] && $urandom_range(0, 9) < 6) begin act[i] = 1; rnd_params(i); end
      req0 = act[0]; we0 = rw[0]; sel0 = rs[0]; addr0 = ra[0]; wdata0 = rd[0];
      req1 = act[1]; we1 = rw[1]; sel1 = rs[1]; addr1 = ra[1]; wdata1 = rd[1];
      step(g);
      if (g >= 0) begin
        if ($urandom_range(0, 2) == 0) act[g] = 0; else rnd_params(g);
      end
    end
    req0 = 0; req1 = 0;
    repeat (4) step(g);
    chk("drain_pending", pq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmem_port_arbiter.md
Name: cmem_port_arbiter

Overview:
- Shares the single layer-memory port (csel/cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between two requesters: requester 0 (conv/pool compute engine) and requester 1 (host readback/debug engine).
- Round-robin arbitration with a bounded burst per owner.
- Registers every memory-side command and returns read data tagged to the issuing requester.
- Sits between the compute engines and the L0/L1 layer memories.

Parameters:
- AW, 12, memory address width.
- DW, 13, memory data width.
- MAX_BURST, 8, maximum consecutive grants to one requester while the other is requesting (1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0, req1  in  1 each  access request; held until granted.
- we0, we1  in  1 each  1 = write, 0 = read.
- sel0, sel1  in  1 each  memory select (0 = L0, 1 = L1).
- addr0, addr1  in  AW each  access address.
- wdata0, wdata1  in  DW each  write data.
- gnt0, gnt1  out  1 each  combinational; request accepted this cycle.
- rvalid0, rvalid1  out  1 each  read data valid for that requester.
- rdata  out  DW  registered read data (shared bus).
- cwr  out  1  memory write strobe.
- crd  out  1  memory read strobe.
- csel  out  1  memory select.
- caddr_wr  out  AW  write address.
- caddr_rd  out  AW  read address.
- cdata_wr  out  DW  write data.
- cdata_rd  in  DW  memory read data; valid during the cycle after crd/caddr_rd are registered.
- busy  out  1  high while any command or read return is in flight.

Behaviour:
- Reset (reset = 0, async) clears these to 0: cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, rdata, rvalid0/1, busy, burst_cnt. last_owner resets to 1, so requester 0 wins the first contention.
- Reset mid-operation discards any in-flight read. No rvalid is produced for it after reset releases.
- Arbitration (combinational, cycle t):
  - only one req high -> grant it;
  - both high, current owner's burst_cnt < MAX_BURST and owner won last cycle -> keep owner;
  - otherwise grant the requester that is not last_owner.
- At most one gnt per cycle; gnt only when the matching req is high.
- burst_cnt: increments when the same requester is granted on consecutive cycles. Resets to 1 on an owner change. Resets to 0 on a cycle with no grant.
- A lone requester is never throttled; burst_cnt saturates at MAX_BURST.
- Command issue (edge ending t, visible t+1):
  - Grant with we = 1: cwr = 1, crd = 0, caddr_wr = addr, cdata_wr = wdata, csel = sel.
  - Grant with we = 0: crd = 1, cwr = 0, caddr_rd = addr, csel = sel.
  - No grant: cwr = crd = 0. Addresses, cdata_wr and csel hold their last values.
  - cwr and crd are never both 1.
- Read return: issuing requester id pipelined with crd. At edge ending t+1, rdata <= cdata_rd and rvalid{id} <= 1 for one cycle, so read latency is 2 cycles from gnt.
- Back-to-back grants: one command per cycle. Each read returns in issue order; there is no reordering.
- Write-after-read to the same address in consecutive cycles: the read returns pre-write data (the memory is single-port and commands are serialized).
- busy = crd | cwr | any rvalid | req0 | req1.
- Requester obligations (not checked): addr, we, sel and wdata stable while req is high and not yet granted.

Test Plan:
- Reset, then req0 alone reads addr 12'h005 on L0, memory returns 13'h0123 -> gnt0 in t, crd = 1 and caddr_rd = 12'h005 and csel = 0 in t+1, rvalid0 = 1 and rdata = 13'h0123 in t+2; rvalid1 stays 0.
- req1 alone writes 13'h1ABC to addr 12'h3FF on L1 -> gnt1 in t; cwr = 1, caddr_wr = 12'h3FF, cdata_wr = 13'h1ABC, csel = 1 in t+1; crd = 0 throughout.
- Both req held continuously from reset, MAX_BURST = 8:
  - first cycle grants requester 0;
  - gnt0 for 8 cycles, then gnt1 for 8, alternating;
  - never both gnt high.
- req0 alone for 20 cycles -> gnt0 every cycle with no throttling; 20 strobes issued.
- Interleaved reads: gnt0 read @10, gnt1 read @20, gnt0 read @30 on consecutive cycles -> rvalid0, rvalid1, rvalid0 on consecutive cycles with matching data in order.
- reset asserted the cycle after a read grant -> all outputs 0 immediately. After release, no rvalid appears for the lost read, and the first contention grants requester 0.
